// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter
// that steers the 4:1 multiplexer select.
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic [7:0] hold_cnt;

  modport master (output req, input gnt, sel, busy, hold_cnt);
  modport slave  (input req, output gnt, sel, busy, hold_cnt);
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 mux: one-hot registered grant, sticky
// select, and a hold limit that forces rotation under contention.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  mux4_rr_arbiter_if.slave bus
);
  localparam logic [7:0] MAXH = 8'(MAX_HOLD);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_gnt, w_gnt_nxt;
  logic [1:0] r_sel, w_sel_nxt;
  logic [1:0] r_ptr, w_ptr_nxt;
  logic [7:0] r_hold, w_hold_nxt;
  logic       r_busy;

  logic [3:0] w_req;
  logic [3:0] w_others;
  logic       w_win_vld, w_rot_vld;
  logic [1:0] w_win_idx, w_rot_idx;
  logic       w_issue;
  logic [1:0] w_issue_idx;

  // First set bit scanning start, start+1, ... (mod 4); MSB of result = found.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] idx;
    pick = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (r[idx]) pick = {1'b1, idx};
    end
  endfunction

  assign w_req    = bus.req;
  assign w_others = w_req & ~r_gnt;
  assign {w_win_vld, w_win_idx} = pick(w_req, r_ptr);
  // r_ptr is g+1 while granted and g is masked out, so the holder never re-wins.
  assign {w_rot_vld, w_rot_idx} = pick(w_others, r_ptr);

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold;
    w_issue     = 1'b0;
    w_issue_idx = w_win_idx;
    case (r_state)
      S_IDLE: begin
        if (w_win_vld) w_issue = 1'b1;
      end
      S_GRANT: begin
        if (!w_req[r_sel]) begin
          if (w_win_vld) begin
            w_issue = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_gnt_nxt   = 4'b0000;
            w_hold_nxt  = 8'd0;
          end
        end else if (r_hold == MAXH && w_rot_vld) begin
          w_issue     = 1'b1;
          w_issue_idx = w_rot_idx;
        end else if (r_hold != MAXH) begin
          w_hold_nxt = r_hold + 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = 4'b0000;
        w_hold_nxt  = 8'd0;
      end
    endcase
    if (w_issue) begin
      w_state_nxt = S_GRANT;
      w_gnt_nxt   = 4'b0001 << w_issue_idx;
      w_sel_nxt   = w_issue_idx;
      w_ptr_nxt   = w_issue_idx + 2'd1;
      w_hold_nxt  = 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_gnt   <= 4'b0000;
      r_sel   <= 2'b00;
      r_ptr   <= 2'b00;
      r_hold  <= 8'd0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
      r_hold  <= w_hold_nxt;
      r_busy  <= |w_gnt_nxt;
    end
  end

  assign bus.gnt      = r_gnt;
  assign bus.sel      = r_sel;
  assign bus.busy     = r_busy;
  assign bus.hold_cnt = r_hold;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Drives two arbiters (MAX_HOLD=8 and MAX_HOLD=1) with the same requests and
// compares them against a round-robin reference model each cycle.
module tb_mux4_rr_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] tb_req = 4'b0000;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux4_rr_arbiter_if bus0();
  mux4_rr_arbiter_if bus1();
  assign bus0.req = tb_req;
  assign bus1.req = tb_req;

  mux4_rr_arbiter #(.MAX_HOLD(8)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  mux4_rr_arbiter #(.MAX_HOLD(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  logic [14:0] obs [2];
  assign obs[0] = {bus0.gnt, bus0.sel, bus0.busy, bus0.hold_cnt};
  assign obs[1] = {bus1.gnt, bus1.sel, bus1.busy, bus1.hold_cnt};

  // Reference: owner (-1 = none), last granted source, held cycles, sticky sel.
  int maxh [2] = '{8, 1};
  int mg   [2];
  int mlast[2];
  int mh   [2];
  int ms   [2];

  function automatic int first_req(input logic [3:0] r, input int start, input int excl);
    for (int i = 0; i < 4; i++) begin
      int idx;
      idx = (start + i) % 4;
      if (r[idx] && idx != excl) return idx;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        mg[k] = -1; mlast[k] = 3; mh[k] = 0; ms[k] = 0;
      end else begin
        int w;
        w = -1;
        if (mg[k] < 0 || !tb_req[mg[k]]) begin
          w = first_req(tb_req, (mlast[k] + 1) % 4, -1);
          if (w < 0) begin mg[k] = -1; mh[k] = 0; end
        end else if (mh[k] == maxh[k] && first_req(tb_req, 0, mg[k]) >= 0) begin
          w = first_req(tb_req, (mg[k] + 1) % 4, mg[k]);
        end else if (mh[k] < maxh[k]) begin
          mh[k] = mh[k] + 1;
        end
        if (w >= 0) begin
          mg[k] = w; mlast[k] = w; ms[k] = w; mh[k] = 1;
        end
      end
    end
  end

  function automatic logic [14:0] exp_vec(input int k);
    logic [3:0] g;
    g = (mg[k] < 0) ? 4'b0000 : (4'b0001 << mg[k]);
    return {g, 2'(ms[k]), (mg[k] >= 0), 8'(mh[k])};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tb_req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tb_req = 4'b1111;
    repeat (5) tick();
    #3;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== 15'd0) begin
        errors++;
        $display("FAIL reset_async dut%0d got=%h want=%h", k, obs[k], 15'd0);
      end
    end
    tb_req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== 15'd0) begin
          errors++;
          $display("FAIL reset_idle dut%0d got=%h want=%h", k, obs[k], 15'd0);
        end
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    tb_req = 4'b0100;
    for (int c = 1; c <= 12; c++) begin
      tick();
      checks++;
      if (obs[0] !== {4'b0100, 2'b10, 1'b1, 8'((c > 8) ? 8 : c)}) begin
        errors++;
        $display("FAIL single_hold c=%0d got=%h want=%h", c, obs[0],
                 {4'b0100, 2'b10, 1'b1, 8'((c > 8) ? 8 : c)});
      end
      checks++;
      if (obs[1] !== exp_vec(1)) begin
        errors++;
        $display("FAIL single_model dut1 got=%h want=%h", obs[1], exp_vec(1));
      end
    end
    tb_req = 4'b0000;
    tick();
    checks++;
    if (obs[0] !== {4'b0000, 2'b10, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL single_drop got=%h want=%h", obs[0], {4'b0000, 2'b10, 1'b0, 8'd0});
    end
  endtask

  task automatic test_contention();
    do_reset();
    tb_req = 4'b1111;
    for (int c = 0; c < 40; c++) begin
      logic [1:0] idx;
      tick();
      idx = 2'((c / 8) % 4);
      checks++;
      if (bus0.gnt !== (4'b0001 << idx) || bus0.sel !== idx) begin
        errors++;
        $display("FAIL contention c=%0d gnt=%b sel=%0d want_idx=%0d", c, bus0.gnt, bus0.sel, idx);
      end
      checks++;
      if (obs[1] !== exp_vec(1)) begin
        errors++;
        $display("FAIL contention_model dut1 got=%h want=%h", obs[1], exp_vec(1));
      end
    end
  endtask

  task automatic test_handoff();
    do_reset();
    tb_req = 4'b0011;
    repeat (3) tick();
    checks++;
    if (bus0.gnt !== 4'b0001 || bus0.hold_cnt !== 8'd3) begin
      errors++;
      $display("FAIL handoff_pre gnt=%b hold=%0d want 0001/3", bus0.gnt, bus0.hold_cnt);
    end
    tb_req = 4'b0010;
    tick();
    checks++;
    if (obs[0] !== {4'b0010, 2'b01, 1'b1, 8'd1}) begin
      errors++;
      $display("FAIL handoff got=%h want=%h", obs[0], {4'b0010, 2'b01, 1'b1, 8'd1});
    end
  endtask

  task automatic test_hog();
    do_reset();
    tb_req = 4'b0010;
    for (int c = 1; c <= 20; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          errors++;
          $display("FAIL hog_model dut%0d c=%0d got=%h want=%h", k, c, obs[k], exp_vec(k));
        end
      end
    end
    checks++;
    if (bus0.gnt !== 4'b0010 || bus0.hold_cnt !== 8'd8) begin
      errors++;
      $display("FAIL hog_sat gnt=%b hold=%0d want 0010/8", bus0.gnt, bus0.hold_cnt);
    end
    tb_req = 4'b1010;
    tick();
    checks++;
    if (obs[0] !== {4'b1000, 2'b11, 1'b1, 8'd1}) begin
      errors++;
      $display("FAIL hog_rotate got=%h want=%h", obs[0], {4'b1000, 2'b11, 1'b1, 8'd1});
    end
  endtask

  task automatic test_fairness();
    do_reset();
    tb_req = 4'b1000;
    tick();
    tb_req = 4'b1001;
    tick();
    checks++;
    if (bus0.gnt !== 4'b1000) begin
      errors++;
      $display("FAIL fair_hold gnt=%b want=1000", bus0.gnt);
    end
    tb_req = 4'b0001;
    tick();
    checks++;
    if (bus0.gnt !== 4'b0001 || bus0.sel !== 2'b00) begin
      errors++;
      $display("FAIL fair_ptr gnt=%b sel=%0d want 0001/0", bus0.gnt, bus0.sel);
    end
    do_reset();
    tb_req = 4'b0101;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (bus1.gnt !== ((c % 2 == 0) ? 4'b0001 : 4'b0100)) begin
        errors++;
        $display("FAIL fair_alt c=%0d gnt=%b want=%b", c, bus1.gnt,
                 (c % 2 == 0) ? 4'b0001 : 4'b0100);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(3) == 0) tb_req[b] = ~tb_req[b];
      if ($urandom_range(31) == 0) tb_req = 4'b0000;
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          errors++;
          $display("FAIL random dut%0d c=%0d got=%h want=%h", k, c, obs[k], exp_vec(k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_handoff();
    test_hog();
    test_fairness();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares the 4:1 single-bit multiplexer datapath (4 data inputs, 2-bit select) between four requesters. It takes one request line per source, grants exactly one source at a time, and drives the multiplexer select with the granted index. A hold limit forces rotation so that no source monopolises the output. It sits directly in front of the 4:1 multiplexer's select input.

## Interface
- MAX_HOLD, 8, maximum consecutive cycles one grant is held while another request is pending; legal range 1..255
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- req  input  4  request per source; req[i] high = source i wants the multiplexer
- gnt  output  4  one-hot grant, or 4'b0000 when idle; registered
- sel  output  2  binary index of current or last grant; drives the multiplexer select; registered
- busy  output  1  high when gnt != 0; registered
- hold_cnt  output  8  cycles the current grant has been held, saturating at MAX_HOLD; registered

## Operation
- State: two-state FSM. IDLE (gnt=0) and GRANT (one gnt bit high). Also a 2-bit priority pointer ptr and the 8-bit hold counter.
- Arbitration function: starting at ptr, scan ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first index with req high wins.
- IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise go to GRANT with the winner index w: gnt = 1<<w, sel = w, hold_cnt = 1, ptr = w+1 (mod 4).
- GRANT on index g:
  - Release: req[g] low. If other requests are present, grant the winner directly (zero-gap handoff, ptr = w+1). Otherwise go to IDLE.
  - Forced rotation: req[g] high, hold_cnt == MAX_HOLD, and any req[j] high for j != g. Grant the winner, searching from ptr (= g+1), so g is never the winner. Set hold_cnt = 1.
  - Hold: req[g] high and no forced rotation. Keep the grant; hold_cnt increments and saturates at MAX_HOLD.
- sel:
  - Updates only when a new grant is issued.
  - In IDLE, sel keeps the last granted index, so the multiplexer output does not glitch between bursts.
- busy = |gnt. hold_cnt = 0 in IDLE.
- Simultaneous events:
  - Release and forced rotation in the same cycle: release takes precedence. The behaviour is the same, since both rotate.
  - New requests arriving while a grant is held wait; they are considered at the next release or rotation.
- ptr only changes when a grant is issued. Requests that drop before being granted are ignored, with no latching.

## Timing
- Reset (rst_n low, asynchronous):
  - gnt = 4'b0000, sel = 2'b00, busy = 0, hold_cnt = 0, ptr = 0, FSM = IDLE.
  - These values apply immediately, with no clock needed, including mid-grant.
- Release of reset is sampled on the first rising clk edge with rst_n high.
- Grant latency: req sampled high at edge N gives gnt/sel/busy valid after edge N+1, one cycle.
- Release latency: req[g] sampled low at edge N. Then gnt[g] drops after edge N+1, and the next gnt (if any) rises in the same cycle, so there are no dead cycles between grantees.
- Forced rotation: a grant held continuously with contention lasts exactly MAX_HOLD cycles. With MAX_HOLD=1, grants rotate every cycle.
- Requesters must keep req high until they see gnt. The multiplexer data path is combinational; the granted source's data is valid at the multiplexer output in the same cycle sel changes.

## Test plan
- Reset values: assert rst_n=0 mid-cycle with req=4'b1111 -> gnt=0000, sel=00, busy=0, hold_cnt=0 immediately; after release with req=0 the outputs stay unchanged.
- Single request: req=4'b0100 at edge 1 -> gnt=0100, sel=10, busy=1 after edge 2; hold_cnt counts 1..8 and stays 8; drop req -> gnt=0000 one cycle later, sel stays 10.
- Full contention, MAX_HOLD=8: req=4'b1111 constant from reset -> grants 0,1,2,3,0 in sequence, each exactly 8 cycles, no gap cycles, and sel follows 00,01,10,11,00.
- Zero-gap handoff: req=4'b0011, source 0 granted, then source 0 drops req after 3 cycles -> gnt goes 0001 -> 0010 in one edge, with hold_cnt reset to 1.
- Lone hog: req=4'b0010 for 20 cycles -> gnt=0010 throughout, hold_cnt saturates at 8. Then raise req[3] -> gnt=1000 on the next edge after it is sampled.
- Pointer fairness: source 3 granted and released while req=4'b1001 -> source 0 wins next, not source 3. With MAX_HOLD=1 and req=4'b0101 -> grants alternate 0001/0100 every cycle.
